pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the SHA core, replacing the fixed 32-bit start-gated PC register.
- Adds a run-control FSM, branch/jump redirect, trap entry with saved EPC, mret return, halt, misalignment detection and a PC-advance counter.
- Sits between the next-PC mux/branch unit and instruction memory; drives the fetch address and fetch-valid strobe.

Parameters:
- XLEN, 32, datapath width of PC, targets, EPC and counter (≥8).
- RESET_VEC, 0, PC value after reset and while in IDLE.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- ILEN_BYTES, 4, sequential increment; targets must be aligned to this (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; run enable. Low pauses PC in RUN.
- stall  in  1  hold PC this cycle (pipeline hazard).
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  branch/jump destination.
- trap_req  in  1  ecall/exception; enter trap.
- mret_req  in  1  return from trap to EPC.
- halt_req  in  1  stop execution permanently until reset.
- pc_out  out  XLEN  current fetch address.
- pc_seq  out  XLEN  pc_out + ILEN_BYTES, combinational, wraps mod 2^XLEN.
- epc_out  out  XLEN  saved exception PC.
- fetch_valid  out  1  pc_out is a valid fetch this cycle.
- misalign_err  out  1  one-cycle registered pulse on misaligned redirect.
- state_out  out  2  00 IDLE, 01 RUN, 10 HALTED.
- adv_count  out  XLEN  number of PC updates taken in RUN, wraps.

Behaviour:
- Reset (async, reset=0): state IDLE, pc_out=RESET_VEC, epc_out=0, misalign_err=0, adv_count=0. Release is synchronous to the next clk edge.
- IDLE:
  - pc_out holds RESET_VEC; fetch_valid=0.
  - start=1 → RUN next cycle, pc unchanged. First fetch is RESET_VEC.
  - All other requests in IDLE are ignored.
- RUN:
  - fetch_valid = start & ~stall (combinational).
  - Updates apply only when start=1. With start=0, all state holds, requests are ignored, and misalign_err=0.
  - Priority per cycle, highest first:
    1. halt_req: state→HALTED; pc holds.
    2. trap_req: epc←pc_out; pc←TRAP_VEC.
    3. mret_req: pc←epc_out.
    4. redirect_valid with target aligned: pc←redirect_target.
    5. redirect_valid with target misaligned (target mod ILEN_BYTES ≠ 0): epc←pc_out; pc←TRAP_VEC; misalign_err=1 next cycle.
    6. stall: hold.
    7. Otherwise: pc←pc_seq.
  - Redirect, trap and mret override stall (resolved in later stages). Stall only blocks sequential advance.
  - trap_req and mret_req in the same cycle: trap wins; epc is overwritten with pc_out.
  - adv_count increments on every cycle in which pc_out changes source (rows 2–5 and 7), even if the new value equals the old one. No increment on halt, stall or pause.
  - Sequential wrap: pc at 2^XLEN−ILEN_BYTES advances to 0, with no error.
- HALTED:
  - fetch_valid=0; pc, epc and adv_count frozen; all inputs ignored.
  - Exit only via reset.
- misalign_err: registered; high exactly one cycle per misaligned redirect; 0 otherwise.
- Reset asserted mid-operation (any state, any cycle): immediate return to reset values, without waiting for clk.
- pc_seq and state_out are always valid, including during reset.

Test Plan:
1. Reset low, then high; start=1 at cycle 2 → state 00→01; pc_out sequence 0,0,4,8,C; fetch_valid rises with RUN; adv_count=3 after three advances.
2. RUN at pc=0x10; stall=1 for 2 cycles, then redirect_valid=1 with target 0x40 while stall=1 → pc holds 0x10 for 2 cycles, then 0x40; adv_count +1.
3. pc=0x24, trap_req=1 → pc=0x100, epc=0x24. Two sequential steps to 0x108, then mret_req=1 → pc=0x24. Also trap_req+mret_req together at pc=0x30 → pc=0x100, epc=0x30.
4. redirect_valid with target 0x42 at pc=0x18 → pc=0x100, epc=0x18, misalign_err pulses high for exactly one cycle.
5. start dropped for 3 cycles at pc=0x8 with redirect_valid=1 → pc stays 0x8, fetch_valid=0, adv_count unchanged. Also halt_req with trap_req → HALTED, pc frozen, later start/trap ignored until reset.
6. XLEN=8, ILEN_BYTES=4 at pc=0xFC, sequential step → pc=0x00. Async reset pulse mid-cycle while in RUN → pc=RESET_VEC and state IDLE before the next clk edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: run-control FSM, redirect/trap/mret sequencing, halt,
// misaligned-target detection and a count of PC updates taken while running.
module pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
  parameter int              ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq,
  output logic [XLEN-1:0] epc_out,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic [1:0]      state_out,
  output logic [XLEN-1:0] adv_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ILEN       = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ILEN - 1'b1;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] epc, epc_nxt;
  logic [XLEN-1:0] adv, adv_nxt;
  logic            merr, merr_nxt;
  logic            misaligned;

  assign pc_seq     = pc + ILEN;
  assign misaligned = |(redirect_target & ALIGN_MASK);

  assign pc_out       = pc;
  assign epc_out      = epc;
  assign adv_count    = adv;
  assign misalign_err = merr;
  assign state_out    = state;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    epc_nxt     = epc;
    adv_nxt     = adv;
    merr_nxt    = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        fetch_valid = start & ~stall;
        // Control flow changes override stall; stall only blocks the sequential step.
        if (start) begin
          if (halt_req) begin
            state_nxt = HALTED;
          end else begin
            if (trap_req) begin
              epc_nxt = pc;
              pc_nxt  = TRAP_VEC;
            end else if (mret_req) begin
              pc_nxt = epc;
            end else if (redirect_valid && !misaligned) begin
              pc_nxt = redirect_target;
            end else if (redirect_valid) begin
              epc_nxt  = pc;
              pc_nxt   = TRAP_VEC;
              merr_nxt = 1'b1;
            end else if (!stall) begin
              pc_nxt = pc_seq;
            end
            if (trap_req || mret_req || redirect_valid || !stall) adv_nxt = adv + 1'b1;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_VEC;
      epc   <= '0;
      adv   <= '0;
      merr  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
      adv   <= adv_nxt;
      merr  <= merr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 32-bit instance for control flow and an
// 8-bit instance for sequential wrap-around.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_req = 1'b0, mret_req = 1'b0, halt_req = 1'b0;
  logic [31:0] pc_out, pc_seq, epc_out, adv_count;
  logic        fetch_valid, misalign_err;
  logic [1:0]  state_out;

  logic        b_reset = 1'b0;
  logic        b_start = 1'b0, b_stall = 1'b0, b_redirect_valid = 1'b0;
  logic [7:0]  b_redirect_target = '0;
  logic        b_trap_req = 1'b0, b_mret_req = 1'b0, b_halt_req = 1'b0;
  logic [7:0]  b_pc_out, b_pc_seq, b_epc_out, b_adv_count;
  logic        b_fetch_valid, b_misalign_err;
  logic [1:0]  b_state_out;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .mret_req(mret_req), .halt_req(halt_req),
    .pc_out(pc_out), .pc_seq(pc_seq), .epc_out(epc_out),
    .fetch_valid(fetch_valid), .misalign_err(misalign_err),
    .state_out(state_out), .adv_count(adv_count)
  );

  pc_unit #(.XLEN(8), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .ILEN_BYTES(4)) dut8 (
    .clk(clk), .reset(b_reset), .start(b_start), .stall(b_stall),
    .redirect_valid(b_redirect_valid), .redirect_target(b_redirect_target),
    .trap_req(b_trap_req), .mret_req(b_mret_req), .halt_req(b_halt_req),
    .pc_out(b_pc_out), .pc_seq(b_pc_seq), .epc_out(b_epc_out),
    .fetch_valid(b_fetch_valid), .misalign_err(b_misalign_err),
    .state_out(b_state_out), .adv_count(b_adv_count)
  );

  typedef struct {
    bit          sel;
    logic [31:0] pc, seq, epc, adv;
    logic [1:0]  st;
    logic        fv, me;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   next_id = 0;

  task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL chk%0d %s: got %h, expected %h", id, nm, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t r;
    if (sbq.size() != 0) begin
      r = sbq.pop_front();
      if (r.sel) begin
        cmp(r.id, "b_pc_out",    {24'h0, b_pc_out},    r.pc);
        cmp(r.id, "b_pc_seq",    {24'h0, b_pc_seq},    r.seq);
        cmp(r.id, "b_epc_out",   {24'h0, b_epc_out},   r.epc);
        cmp(r.id, "b_adv_count", {24'h0, b_adv_count}, r.adv);
        cmp(r.id, "b_state",     {30'h0, b_state_out}, {30'h0, r.st});
        cmp(r.id, "b_fetch_vld", {31'h0, b_fetch_valid}, {31'h0, r.fv});
        cmp(r.id, "b_misalign",  {31'h0, b_misalign_err}, {31'h0, r.me});
      end else begin
        cmp(r.id, "pc_out",    pc_out,    r.pc);
        cmp(r.id, "pc_seq",    pc_seq,    r.seq);
        cmp(r.id, "epc_out",   epc_out,   r.epc);
        cmp(r.id, "adv_count", adv_count, r.adv);
        cmp(r.id, "state",     {30'h0, state_out}, {30'h0, r.st});
        cmp(r.id, "fetch_vld", {31'h0, fetch_valid}, {31'h0, r.fv});
        cmp(r.id, "misalign",  {31'h0, misalign_err}, {31'h0, r.me});
      end
    end
  end

  task automatic push(input bit sel, input logic [31:0] pc, input logic [31:0] epc,
                      input logic [1:0] st, input logic fv, input logic me, input logic [31:0] adv);
    exp_t e;
    e.sel = sel;
    e.pc  = pc;
    e.seq = sel ? ((pc + 32'd4) & 32'hFF) : (pc + 32'd4);
    e.epc = epc;
    e.adv = adv;
    e.st  = st;
    e.fv  = fv;
    e.me  = me;
    e.id  = next_id;
    next_id++;
    sbq.push_back(e);
  endtask

  task automatic chk_a(input logic [31:0] pc, input logic [31:0] epc, input logic [1:0] st,
                       input logic fv, input logic me, input logic [31:0] adv);
    push(1'b0, pc, epc, st, fv, me, adv);
  endtask

  task automatic chk_b(input logic [31:0] pc, input logic [1:0] st, input logic fv,
                       input logic [31:0] adv);
    push(1'b1, pc, 32'h0, st, fv, 1'b0, adv);
  endtask

  task automatic drv_a(input logic s, input logic stl, input logic rv, input logic [31:0] rt,
                       input logic tr, input logic mr, input logic hr);
    start = s; stall = stl; redirect_valid = rv; redirect_target = rt;
    trap_req = tr; mret_req = mr; halt_req = hr;
  endtask

  task automatic drv_b(input logic s, input logic rv, input logic [7:0] rt);
    b_start = s; b_redirect_valid = rv; b_redirect_target = rt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick; tick;
    // Reset state
    drv_a(0,0,0,0,0,0,0); chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    reset = 1'b1; b_reset = 1'b1;
    chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    // Start and sequential advance
    drv_a(1,0,0,0,0,0,0); chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    chk_a(32'h0, 0, 2'b01, 1, 0, 0); tick;
    chk_a(32'h4, 0, 2'b01, 1, 0, 1); tick;
    chk_a(32'h8, 0, 2'b01, 1, 0, 2); tick;
    chk_a(32'hC, 0, 2'b01, 1, 0, 3); tick;
    // Stall, then redirect under stall
    drv_a(1,1,0,0,0,0,0); chk_a(32'h10, 0, 2'b01, 0, 0, 4); tick;
    chk_a(32'h10, 0, 2'b01, 0, 0, 4); tick;
    drv_a(1,1,1,32'h40,0,0,0); chk_a(32'h10, 0, 2'b01, 0, 0, 4); tick;
    drv_a(1,0,1,32'h24,0,0,0); chk_a(32'h40, 0, 2'b01, 1, 0, 5); tick;
    // Trap, sequential steps, mret
    drv_a(1,0,0,0,1,0,0); chk_a(32'h24, 0, 2'b01, 1, 0, 6); tick;
    drv_a(1,0,0,0,0,0,0); chk_a(32'h100, 32'h24, 2'b01, 1, 0, 7); tick;
    chk_a(32'h104, 32'h24, 2'b01, 1, 0, 8); tick;
    drv_a(1,0,0,0,0,1,0); chk_a(32'h108, 32'h24, 2'b01, 1, 0, 9); tick;
    drv_a(1,0,1,32'h30,0,0,0); chk_a(32'h24, 32'h24, 2'b01, 1, 0, 10); tick;
    drv_a(1,0,0,0,1,1,0); chk_a(32'h30, 32'h24, 2'b01, 1, 0, 11); tick;
    // Misaligned redirect
    drv_a(1,0,1,32'h18,0,0,0); chk_a(32'h100, 32'h30, 2'b01, 1, 0, 12); tick;
    drv_a(1,0,1,32'h42,0,0,0); chk_a(32'h18, 32'h30, 2'b01, 1, 0, 13); tick;
    drv_a(1,0,0,0,0,0,0); chk_a(32'h100, 32'h18, 2'b01, 1, 1, 14); tick;
    chk_a(32'h104, 32'h18, 2'b01, 1, 0, 15); tick;
    // Pause with a pending redirect
    drv_a(1,0,1,32'h8,0,0,0); chk_a(32'h108, 32'h18, 2'b01, 1, 0, 16); tick;
    drv_a(0,0,1,32'h40,0,0,0);
    for (int i = 0; i < 3; i++) begin
      chk_a(32'h8, 32'h18, 2'b01, 0, 0, 17); tick;
    end
    drv_a(1,0,0,0,0,0,0); chk_a(32'h8, 32'h18, 2'b01, 1, 0, 17); tick;
    // Halt beats trap; halted unit ignores everything
    drv_a(1,0,0,0,1,0,1); chk_a(32'hC, 32'h18, 2'b01, 1, 0, 18); tick;
    drv_a(1,0,0,0,1,0,0); chk_a(32'hC, 32'h18, 2'b10, 0, 0, 18); tick;
    drv_a(1,0,1,32'h40,0,1,0); chk_a(32'hC, 32'h18, 2'b10, 0, 0, 18); tick;
    drv_a(1,0,0,0,0,0,0); chk_a(32'hC, 32'h18, 2'b10, 0, 0, 18); tick;
    // Reset out of HALTED, then asynchronous reset mid-cycle while running
    reset = 1'b0; drv_a(0,0,0,0,0,0,0); chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    reset = 1'b1; drv_a(1,0,0,0,0,0,0); chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    chk_a(32'h0, 0, 2'b01, 1, 0, 0); tick;
    chk_a(32'h4, 0, 2'b01, 1, 0, 1); tick;
    #2 reset = 1'b0;
    chk_a(32'h0, 0, 2'b00, 0, 0, 0); tick;
    reset = 1'b1; drv_a(0,0,0,0,0,0,0);
    // 8-bit instance: wrap from 0xFC to 0x00
    drv_b(1, 0, 8'h00); chk_b(32'h00, 2'b00, 0, 0); tick;
    drv_b(1, 1, 8'hFC); chk_b(32'h00, 2'b01, 1, 0); tick;
    drv_b(1, 0, 8'h00); chk_b(32'hFC, 2'b01, 1, 1); tick;
    chk_b(32'h00, 2'b01, 1, 2); tick;
    tick; tick;
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
